// File: rtl/mem_wb_reg.sv
// Dual-issue MEM->WB pipeline register. Selects per-slot writeback data (ALU or Dcache),
// qualifies register writes, and serialises the two-cycle Dcache access when both slots
// touch memory in the same cycle by parking slot0's load data in a hold register.
module mem_wb_reg #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      EXMem_Valid_0,
    input  logic                      EXMem_Valid_1,
    input  logic                      EXMem_RegWr_0,
    input  logic                      EXMem_RegWr_1,
    input  logic [REG_ADDR_WIDTH-1:0] EXMem_Rd_0,
    input  logic [REG_ADDR_WIDTH-1:0] EXMem_Rd_1,
    input  logic [DATA_WIDTH-1:0]     EXMem_AluData_0,
    input  logic [DATA_WIDTH-1:0]     EXMem_AluData_1,
    input  logic                      Mem_LdEN_0,
    input  logic                      Mem_LdEN_1,
    input  logic                      Mem_Stall,
    input  logic [DATA_WIDTH-1:0]     Dcache_DataRd_0,
    input  logic [DATA_WIDTH-1:0]     Dcache_DataRd_1,
    input  logic                      Hold,
    input  logic                      Flush,
    output logic                      MemWB_Valid_0,
    output logic                      MemWB_Valid_1,
    output logic                      MemWB_RegWr_0,
    output logic                      MemWB_RegWr_1,
    output logic [REG_ADDR_WIDTH-1:0] MemWB_Rd_0,
    output logic [REG_ADDR_WIDTH-1:0] MemWB_Rd_1,
    output logic [DATA_WIDTH-1:0]     MemWB_WbData_0,
    output logic [DATA_WIDTH-1:0]     MemWB_WbData_1,
    output logic                      MemWB_Busy
);

    typedef enum logic [0:0] {StFirst, StSecond} state_e;

    state_e                    r_state_q, r_state_d;
    logic                      r_valid_0_q, r_valid_0_d;
    logic                      r_valid_1_q, r_valid_1_d;
    logic                      r_regwr_0_q, r_regwr_0_d;
    logic                      r_regwr_1_q, r_regwr_1_d;
    logic [REG_ADDR_WIDTH-1:0] r_rd_0_q, r_rd_0_d;
    logic [REG_ADDR_WIDTH-1:0] r_rd_1_q, r_rd_1_d;
    logic [DATA_WIDTH-1:0]     r_wb_0_q, r_wb_0_d;
    logic [DATA_WIDTH-1:0]     r_wb_1_q, r_wb_1_d;
    logic [DATA_WIDTH-1:0]     r_hold_q, r_hold_d;

    logic [DATA_WIDTH-1:0] w_wbsel_0;
    logic [DATA_WIDTH-1:0] w_wbsel_1;
    logic                  w_qual_0;
    logic                  w_qual_1;
    logic                  w_regwr_0;
    logic                  w_regwr_1;

    // Per-slot data select and write-enable qualification; younger slot1 wins a WAW tie.
    always_comb begin
        w_wbsel_0 = Mem_LdEN_0 ? Dcache_DataRd_0 : EXMem_AluData_0;
        w_wbsel_1 = Mem_LdEN_1 ? Dcache_DataRd_1 : EXMem_AluData_1;
        w_qual_0  = EXMem_Valid_0 & EXMem_RegWr_0 & (EXMem_Rd_0 != '0);
        w_qual_1  = EXMem_Valid_1 & EXMem_RegWr_1 & (EXMem_Rd_1 != '0);
        w_regwr_0 = w_qual_0 & ~(w_qual_1 & (EXMem_Rd_0 == EXMem_Rd_1));
        w_regwr_1 = w_qual_1;
    end

    // Next-state: Flush beats Hold beats the FIRST/SECOND serialisation sequence.
    always_comb begin
        r_state_d   = r_state_q;
        r_valid_0_d = r_valid_0_q;
        r_valid_1_d = r_valid_1_q;
        r_regwr_0_d = r_regwr_0_q;
        r_regwr_1_d = r_regwr_1_q;
        r_rd_0_d    = r_rd_0_q;
        r_rd_1_d    = r_rd_1_q;
        r_wb_0_d    = r_wb_0_q;
        r_wb_1_d    = r_wb_1_q;
        r_hold_d    = r_hold_q;
        if (Flush) begin
            r_valid_0_d = 1'b0;
            r_valid_1_d = 1'b0;
            r_regwr_0_d = 1'b0;
            r_regwr_1_d = 1'b0;
            r_state_d   = StFirst;
        end else if (!Hold) begin
            unique case (r_state_q)
                StFirst: begin
                    if (Mem_Stall) begin
                        // Park slot0's load data and emit a bubble while slot1's access runs.
                        r_hold_d    = w_wbsel_0;
                        r_valid_0_d = 1'b0;
                        r_valid_1_d = 1'b0;
                        r_regwr_0_d = 1'b0;
                        r_regwr_1_d = 1'b0;
                        r_state_d   = StSecond;
                    end else begin
                        r_valid_0_d = EXMem_Valid_0;
                        r_valid_1_d = EXMem_Valid_1;
                        r_regwr_0_d = w_regwr_0;
                        r_regwr_1_d = w_regwr_1;
                        r_rd_0_d    = EXMem_Rd_0;
                        r_rd_1_d    = EXMem_Rd_1;
                        r_wb_0_d    = w_wbsel_0;
                        r_wb_1_d    = w_wbsel_1;
                    end
                end
                StSecond: begin
                    // Upstream holds EXMem stable, so control comes from the live inputs.
                    r_valid_0_d = EXMem_Valid_0;
                    r_valid_1_d = EXMem_Valid_1;
                    r_regwr_0_d = w_regwr_0;
                    r_regwr_1_d = w_regwr_1;
                    r_rd_0_d    = EXMem_Rd_0;
                    r_rd_1_d    = EXMem_Rd_1;
                    r_wb_0_d    = r_hold_q;
                    r_wb_1_d    = w_wbsel_1;
                    r_state_d   = StFirst;
                end
                default: r_state_d = StFirst;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= StFirst;
            r_valid_0_q <= 1'b0;
            r_valid_1_q <= 1'b0;
            r_regwr_0_q <= 1'b0;
            r_regwr_1_q <= 1'b0;
            r_rd_0_q    <= '0;
            r_rd_1_q    <= '0;
            r_wb_0_q    <= '0;
            r_wb_1_q    <= '0;
            r_hold_q    <= '0;
        end else begin
            r_state_q   <= r_state_d;
            r_valid_0_q <= r_valid_0_d;
            r_valid_1_q <= r_valid_1_d;
            r_regwr_0_q <= r_regwr_0_d;
            r_regwr_1_q <= r_regwr_1_d;
            r_rd_0_q    <= r_rd_0_d;
            r_rd_1_q    <= r_rd_1_d;
            r_wb_0_q    <= r_wb_0_d;
            r_wb_1_q    <= r_wb_1_d;
            r_hold_q    <= r_hold_d;
        end
    end

    // Outputs come straight from registers; Busy is decoded from the state register.
    always_comb begin
        MemWB_Valid_0  = r_valid_0_q;
        MemWB_Valid_1  = r_valid_1_q;
        MemWB_RegWr_0  = r_regwr_0_q;
        MemWB_RegWr_1  = r_regwr_1_q;
        MemWB_Rd_0     = r_rd_0_q;
        MemWB_Rd_1     = r_rd_1_q;
        MemWB_WbData_0 = r_wb_0_q;
        MemWB_WbData_1 = r_wb_1_q;
        MemWB_Busy     = (r_state_q == StSecond);
    end

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed bench for mem_wb_reg: expected bundles are queued as each step is driven and
// popped/compared one cycle later, sampled 1 time unit after the rising edge.
module tb_mem_wb_reg;

    typedef struct packed {
        logic        v0;
        logic        v1;
        logic        w0;
        logic        w1;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v_0, v_1, rw_0, rw_1, ld_0, ld_1, stall, hold, flush;
    logic [4:0]  rd_0, rd_1;
    logic [31:0] alu_0, alu_1, dr_0, dr_1;
    logic        o_v0, o_v1, o_w0, o_w1, o_busy;
    logic [4:0]  o_r0, o_r1;
    logic [31:0] o_d0, o_d1;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    mem_wb_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .EXMem_Valid_0   (v_0),
        .EXMem_Valid_1   (v_1),
        .EXMem_RegWr_0   (rw_0),
        .EXMem_RegWr_1   (rw_1),
        .EXMem_Rd_0      (rd_0),
        .EXMem_Rd_1      (rd_1),
        .EXMem_AluData_0 (alu_0),
        .EXMem_AluData_1 (alu_1),
        .Mem_LdEN_0      (ld_0),
        .Mem_LdEN_1      (ld_1),
        .Mem_Stall       (stall),
        .Dcache_DataRd_0 (dr_0),
        .Dcache_DataRd_1 (dr_1),
        .Hold            (hold),
        .Flush           (flush),
        .MemWB_Valid_0   (o_v0),
        .MemWB_Valid_1   (o_v1),
        .MemWB_RegWr_0   (o_w0),
        .MemWB_RegWr_1   (o_w1),
        .MemWB_Rd_0      (o_r0),
        .MemWB_Rd_1      (o_r1),
        .MemWB_WbData_0  (o_d0),
        .MemWB_WbData_1  (o_d1),
        .MemWB_Busy      (o_busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic v0, logic v1, logic w0, logic w1, logic [4:0] r0,
                                logic [4:0] r1, logic [31:0] d0, logic [31:0] d1,
                                logic busy);
        exp_t e;
        e.v0 = v0; e.v1 = v1; e.w0 = w0; e.w1 = w1;
        e.r0 = r0; e.r1 = r1; e.d0 = d0; e.d1 = d1; e.busy = busy;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected bundle, clock once, then pop it and compare against the outputs.
    task automatic step(input string tag, input exp_t e);
        exp_t g;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({tag, ".valid0"}, 32'(o_v0), 32'(g.v0));
        chk({tag, ".valid1"}, 32'(o_v1), 32'(g.v1));
        chk({tag, ".regwr0"}, 32'(o_w0), 32'(g.w0));
        chk({tag, ".regwr1"}, 32'(o_w1), 32'(g.w1));
        chk({tag, ".rd0"},    32'(o_r0), 32'(g.r0));
        chk({tag, ".rd1"},    32'(o_r1), 32'(g.r1));
        chk({tag, ".wb0"},    o_d0,      g.d0);
        chk({tag, ".wb1"},    o_d1,      g.d1);
        chk({tag, ".busy"},   32'(o_busy), 32'(g.busy));
    endtask

    task automatic slots(input logic a_v, input logic a_w, input logic [4:0] a_r,
                         input logic a_ld, input logic [31:0] a_alu, input logic [31:0] a_dr,
                         input logic b_v, input logic b_w, input logic [4:0] b_r,
                         input logic b_ld, input logic [31:0] b_alu, input logic [31:0] b_dr);
        v_0 = a_v; rw_0 = a_w; rd_0 = a_r; ld_0 = a_ld; alu_0 = a_alu; dr_0 = a_dr;
        v_1 = b_v; rw_1 = b_w; rd_1 = b_r; ld_1 = b_ld; alu_1 = b_alu; dr_1 = b_dr;
    endtask

    initial begin
        // Reset with random inputs on every other port.
        rst = 1'b1;
        slots(1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom,
              1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom);
        stall = 1'($urandom); hold = 1'($urandom); flush = 1'($urandom);
        step("reset_a", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("reset_b", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0; stall = 1'b0; hold = 1'b0; flush = 1'b0;
        slots(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Single load in slot0, ALU op in slot1.
        slots(1, 1, 5, 1, 32'h1234, 32'hDEADBEEF, 1, 1, 6, 0, 32'h10, 32'h5555);
        step("single_load", mk(1, 1, 1, 1, 5, 6, 32'hDEADBEEF, 32'h10, 0));

        // Dual load; Mem_Stall left high in cycle B must be ignored.
        stall = 1'b1;
        slots(1, 1, 8, 1, 32'hAAAA, 32'h11, 1, 1, 9, 1, 32'hBBBB, 32'h77);
        step("dual_a", mk(0, 0, 0, 0, 5, 6, 32'hDEADBEEF, 32'h10, 1));
        dr_0 = 32'h99; dr_1 = 32'h22;
        step("dual_b", mk(1, 1, 1, 1, 8, 9, 32'h11, 32'h22, 0));

        // Flush in SECOND drops the held slot0, then a normal bundle follows.
        slots(1, 1, 10, 1, 32'h0, 32'h33, 1, 1, 11, 1, 32'h0, 32'h44);
        step("flush_a", mk(0, 0, 0, 0, 8, 9, 32'h11, 32'h22, 1));
        stall = 1'b0; flush = 1'b1; dr_0 = 32'h99;
        step("flush_b", mk(0, 0, 0, 0, 8, 9, 32'h11, 32'h22, 0));
        flush = 1'b0;
        slots(1, 1, 12, 0, 32'hA, 32'h0, 1, 1, 13, 0, 32'hB, 32'h0);
        step("after_flush", mk(1, 1, 1, 1, 12, 13, 32'hA, 32'hB, 0));

        // WAW on the same rd, x0 destination, store-only slot, invalid slot0.
        slots(1, 1, 7, 0, 32'h70, 0, 1, 1, 7, 0, 32'h71, 0);
        step("waw", mk(1, 1, 0, 1, 7, 7, 32'h70, 32'h71, 0));
        slots(1, 1, 0, 0, 32'h80, 0, 0, 1, 3, 0, 32'h81, 0);
        step("x0_invalid1", mk(1, 0, 0, 0, 0, 3, 32'h80, 32'h81, 0));
        slots(1, 0, 4, 0, 32'h90, 0, 1, 1, 4, 0, 32'h91, 0);
        step("store_waw", mk(1, 1, 0, 1, 4, 4, 32'h90, 32'h91, 0));
        slots(0, 1, 2, 0, 32'hA0, 0, 1, 1, 2, 0, 32'hA1, 0);
        step("invalid0", mk(0, 1, 0, 1, 2, 2, 32'hA0, 32'hA1, 0));

        // Hold in SECOND for three cycles; slot0 data must come from the hold register.
        stall = 1'b1;
        slots(1, 1, 14, 1, 32'h0, 32'h55, 1, 1, 15, 1, 32'h0, 32'h66);
        step("hold_a", mk(0, 0, 0, 0, 2, 2, 32'hA0, 32'hA1, 1));
        hold = 1'b1; stall = 1'b0; dr_0 = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold_%0d", i), mk(0, 0, 0, 0, 2, 2, 32'hA0, 32'hA1, 1));
        end
        hold = 1'b0;
        step("hold_release", mk(1, 1, 1, 1, 14, 15, 32'h55, 32'h66, 0));

        // Hold in FIRST freezes a normal bundle.
        hold = 1'b1;
        slots(1, 1, 20, 0, 32'h200, 0, 1, 1, 21, 0, 32'h210, 0);
        step("hold_first", mk(1, 1, 1, 1, 14, 15, 32'h55, 32'h66, 0));
        hold = 1'b0;
        step("hold_first_rel", mk(1, 1, 1, 1, 20, 21, 32'h200, 32'h210, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
